// File: rtl/cobalt_pkg.sv
// cobalt_pkg: shared default widths, opcodes and the per-entry status record
// used by the cobalt execution queues.
package cobalt_pkg;
    localparam int TAGW_DEF  = 6;
    localparam int DATAW_DEF = 32;
    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_MUL = 4'h2;
    localparam logic [3:0] OP_DIV = 4'h3;
    typedef struct packed {
        logic v;
        logic rsv;
        logic rtv;
    } eflags_t;
    function automatic logic entry_ready(eflags_t f);
        return f.v & f.rsv & f.rtv;
    endfunction
endpackage

// File: rtl/equeue_pick.sv
// equeue_pick: oldest-first priority select; slot 0 wins, yields one-hot grant and index.
module equeue_pick #(
    parameter int N = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);
    assign gnt_o = req_i & (~req_i + 1'b1);
    assign any_o = |req_i;
    always_comb begin
        idx_o = '0;
        for (int i = N - 1; i >= 0; i--) begin
            idx_o = req_i[i] ? IW'(i) : idx_o;
        end
    end
endmodule

// File: rtl/equeue_param.sv
// equeue_param: age-ordered reservation station with CDB wakeup, dispatch bypass,
// oldest-ready issue, compaction on issue and synchronous flush.
module equeue_param
    import cobalt_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int OPW   = 4,
    parameter int TAGW  = TAGW_DEF,
    parameter int DATAW = DATAW_DEF,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int OW = (OPW > 0) ? OPW : 1,
    localparam int IW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             dispatch_en,
    output logic             dispatch_ready,
    input  logic [OW-1:0]    dispatch_opcode,
    input  logic [TAGW-1:0]  dispatch_rdtag,
    input  logic [TAGW-1:0]  dispatch_rstag,
    input  logic [TAGW-1:0]  dispatch_rttag,
    input  logic [DATAW-1:0] dispatch_rsdata,
    input  logic [DATAW-1:0] dispatch_rtdata,
    input  logic             dispatch_rsvalid,
    input  logic             dispatch_rtvalid,
    input  logic             cdb_valid,
    input  logic [TAGW-1:0]  cdb_tag,
    input  logic [DATAW-1:0] cdb_data,
    output logic             issue_ready,
    output logic [OW-1:0]    issue_opcode,
    output logic [TAGW-1:0]  issue_rdtag,
    output logic [DATAW-1:0] issue_rsdata,
    output logic [DATAW-1:0] issue_rtdata,
    input  logic             issue_done,
    output logic [CW-1:0]    count
);
    eflags_t          fl_q  [DEPTH];
    eflags_t          fl_d  [DEPTH];
    logic [OW-1:0]    op_q  [DEPTH];
    logic [OW-1:0]    op_d  [DEPTH];
    logic [TAGW-1:0]  rd_q  [DEPTH];
    logic [TAGW-1:0]  rd_d  [DEPTH];
    logic [TAGW-1:0]  rst_q [DEPTH];
    logic [TAGW-1:0]  rst_d [DEPTH];
    logic [TAGW-1:0]  rtt_q [DEPTH];
    logic [TAGW-1:0]  rtt_d [DEPTH];
    logic [DATAW-1:0] rsd_q [DEPTH];
    logic [DATAW-1:0] rsd_d [DEPTH];
    logic [DATAW-1:0] rtd_q [DEPTH];
    logic [DATAW-1:0] rtd_d [DEPTH];
    logic [CW-1:0]    count_q, count_d;
    // Woken copy of the array with an always-empty slot DEPTH to shift in from the top.
    eflags_t          fl_w  [DEPTH+1];
    logic [OW-1:0]    op_w  [DEPTH+1];
    logic [TAGW-1:0]  rd_w  [DEPTH+1];
    logic [TAGW-1:0]  rst_w [DEPTH+1];
    logic [TAGW-1:0]  rtt_w [DEPTH+1];
    logic [DATAW-1:0] rsd_w [DEPTH+1];
    logic [DATAW-1:0] rtd_w [DEPTH+1];
    logic [DEPTH-1:0] req, gnt;
    logic [IW-1:0]    idx;
    logic             any, take, acc, sh, wr, rs_hit, rt_hit;
    logic [CW-1:0]    pos;
    int               src;
    eflags_t          dfl;
    logic [OW-1:0]    dop;
    logic [DATAW-1:0] drsd, drtd;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            req[i] = entry_ready(fl_q[i]);
        end
    end

    equeue_pick #(.N(DEPTH)) u_pick (
        .req_i (req),
        .gnt_o (gnt),
        .idx_o (idx),
        .any_o (any)
    );

    assign take           = issue_done & any;
    assign dispatch_ready = count_q < CW'(DEPTH);
    assign acc            = dispatch_en & dispatch_ready;
    assign pos            = count_q - CW'(take);
    assign count          = count_q;
    assign issue_ready    = any;
    assign issue_opcode   = any ? op_q[idx]  : '0;
    assign issue_rdtag    = any ? rd_q[idx]  : '0;
    assign issue_rsdata   = any ? rsd_q[idx] : '0;
    assign issue_rtdata   = any ? rtd_q[idx] : '0;

    assign rs_hit = cdb_valid & ~dispatch_rsvalid & (dispatch_rstag == cdb_tag);
    assign rt_hit = cdb_valid & ~dispatch_rtvalid & (dispatch_rttag == cdb_tag);
    assign dfl    = '{v: 1'b1, rsv: dispatch_rsvalid | rs_hit, rtv: dispatch_rtvalid | rt_hit};
    assign drsd   = rs_hit ? cdb_data : dispatch_rsdata;
    assign drtd   = rt_hit ? cdb_data : dispatch_rtdata;
    assign dop    = (OPW > 0) ? dispatch_opcode : '0;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            fl_w[i]     = fl_q[i];
            fl_w[i].rsv = fl_q[i].rsv | (cdb_valid & (rst_q[i] == cdb_tag));
            fl_w[i].rtv = fl_q[i].rtv | (cdb_valid & (rtt_q[i] == cdb_tag));
            rsd_w[i]    = (!fl_q[i].rsv && cdb_valid && rst_q[i] == cdb_tag) ? cdb_data : rsd_q[i];
            rtd_w[i]    = (!fl_q[i].rtv && cdb_valid && rtt_q[i] == cdb_tag) ? cdb_data : rtd_q[i];
            op_w[i]     = op_q[i];
            rd_w[i]     = rd_q[i];
            rst_w[i]    = rst_q[i];
            rtt_w[i]    = rtt_q[i];
        end
        fl_w[DEPTH]  = '0;
        op_w[DEPTH]  = '0;
        rd_w[DEPTH]  = '0;
        rst_w[DEPTH] = '0;
        rtt_w[DEPTH] = '0;
        rsd_w[DEPTH] = '0;
        rtd_w[DEPTH] = '0;
    end

    // Slots at or above the granted one pull from their younger neighbour.
    always_comb begin
        sh  = 1'b0;
        wr  = 1'b0;
        src = 0;
        for (int i = 0; i < DEPTH; i++) begin
            sh       = sh | (take & gnt[i]);
            wr       = acc && (CW'(i) == pos);
            src      = sh ? i + 1 : i;
            fl_d[i]  = wr ? dfl  : fl_w[src];
            op_d[i]  = wr ? dop  : op_w[src];
            rd_d[i]  = wr ? dispatch_rdtag : rd_w[src];
            rst_d[i] = wr ? dispatch_rstag : rst_w[src];
            rtt_d[i] = wr ? dispatch_rttag : rtt_w[src];
            rsd_d[i] = wr ? drsd : rsd_w[src];
            rtd_d[i] = wr ? drtd : rtd_w[src];
            fl_d[i].v = fl_d[i].v & ~flush;
        end
        count_d = flush ? '0 : count_q + CW'(acc) - CW'(take);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                fl_q[i]  <= '0;
                op_q[i]  <= '0;
                rd_q[i]  <= '0;
                rst_q[i] <= '0;
                rtt_q[i] <= '0;
                rsd_q[i] <= '0;
                rtd_q[i] <= '0;
            end
            count_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                fl_q[i]  <= fl_d[i];
                op_q[i]  <= op_d[i];
                rd_q[i]  <= rd_d[i];
                rst_q[i] <= rst_d[i];
                rtt_q[i] <= rtt_d[i];
                rsd_q[i] <= rsd_d[i];
                rtd_q[i] <= rtd_d[i];
            end
            count_q <= count_d;
        end
    end
endmodule

// File: tb/tb_equeue_param.sv
// tb_equeue_param: directed scoreboard bench for the execution queue.
module tb_equeue_param;
    logic        clk = 1'b0;
    logic        reset, flush, dispatch_en, dispatch_ready;
    logic [3:0]  dispatch_opcode, issue_opcode;
    logic [5:0]  dispatch_rdtag, dispatch_rstag, dispatch_rttag, cdb_tag, issue_rdtag;
    logic [31:0] dispatch_rsdata, dispatch_rtdata, cdb_data, issue_rsdata, issue_rtdata;
    logic        dispatch_rsvalid, dispatch_rtvalid, cdb_valid, issue_ready, issue_done;
    logic [2:0]  count;
    int          tests = 0;
    int          fails = 0;

    typedef struct {
        logic [3:0]  op;
        logic [5:0]  rd;
        logic [31:0] rs;
        logic [31:0] rt;
    } exp_t;
    exp_t sb[$];

    equeue_param dut (
        .clk(clk), .reset(reset), .flush(flush),
        .dispatch_en(dispatch_en), .dispatch_ready(dispatch_ready),
        .dispatch_opcode(dispatch_opcode), .dispatch_rdtag(dispatch_rdtag),
        .dispatch_rstag(dispatch_rstag), .dispatch_rttag(dispatch_rttag),
        .dispatch_rsdata(dispatch_rsdata), .dispatch_rtdata(dispatch_rtdata),
        .dispatch_rsvalid(dispatch_rsvalid), .dispatch_rtvalid(dispatch_rtvalid),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .issue_ready(issue_ready), .issue_opcode(issue_opcode), .issue_rdtag(issue_rdtag),
        .issue_rsdata(issue_rsdata), .issue_rtdata(issue_rtdata),
        .issue_done(issue_done), .count(count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [5:0] rd, input logic [5:0] rst, input logic [5:0] rtt,
                         input logic [31:0] rsd, input logic [31:0] rtd,
                         input logic rsv, input logic rtv,
                         input logic [31:0] ers, input logic [31:0] ert, input bit push);
        dispatch_en      = 1'b1;
        dispatch_opcode  = rd[3:0];
        dispatch_rdtag   = rd;
        dispatch_rstag   = rst;
        dispatch_rttag   = rtt;
        dispatch_rsdata  = rsd;
        dispatch_rtdata  = rtd;
        dispatch_rsvalid = rsv;
        dispatch_rtvalid = rtv;
        if (push) sb.push_back('{rd[3:0], rd, ers, ert});
    endtask

    task automatic issue_take(input logic [5:0] rd);
        bit found = 0;
        chk("issue_ready", issue_ready, 1);
        chk("issue_order", issue_rdtag, rd);
        for (int k = 0; k < sb.size(); k++) begin
            if (sb[k].rd == issue_rdtag) begin
                chk("issue_opcode", issue_opcode, sb[k].op);
                chk("issue_rsdata", issue_rsdata, sb[k].rs);
                chk("issue_rtdata", issue_rtdata, sb[k].rt);
                sb.delete(k);
                found = 1;
                break;
            end
        end
        tests++;
        assert (found) else begin
            fails++;
            $error("FAIL sb_lookup: observed rdtag %0h expected an outstanding entry", issue_rdtag);
        end
        issue_done = 1'b1;
        step();
        issue_done = 1'b0;
    endtask

    initial begin
        reset = 0; flush = 0; dispatch_en = 0; issue_done = 0;
        dispatch_opcode = 0; dispatch_rdtag = 0; dispatch_rstag = 0; dispatch_rttag = 0;
        dispatch_rsdata = 0; dispatch_rtdata = 0; dispatch_rsvalid = 0; dispatch_rtvalid = 0;
        cdb_valid = 0; cdb_tag = 0; cdb_data = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", count, 0);
        chk("rst_dready", dispatch_ready, 1);
        chk("rst_iready", issue_ready, 0);
        chk("rst_rdtag", issue_rdtag, 0);
        reset = 1;
        step();
        // ready dispatch, issue next cycle
        drive(1, 0, 0, 2, 2, 1, 1, 2, 2, 1);
        chk("t2_same_cycle", issue_ready, 0);
        step();
        dispatch_en = 0;
        chk("t2_count1", count, 1);
        issue_take(1);
        chk("t2_count0", count, 0);
        // wakeup and age ordering
        drive(3, 5, 0, 0, 1, 0, 1, 32'h77, 1, 1);
        step();
        drive(4, 0, 0, 32'h10, 32'h20, 1, 1, 32'h10, 32'h20, 1);
        chk("t3_a_pending", issue_ready, 0);
        step();
        dispatch_en = 0;
        chk("t3_count2", count, 2);
        cdb_valid = 1; cdb_tag = 5; cdb_data = 32'h77;
        issue_take(4);
        cdb_valid = 0;
        issue_take(3);
        chk("t3_count0", count, 0);
        // dispatch bypass, single and dual operand
        cdb_valid = 1; cdb_tag = 9; cdb_data = 32'hABCD;
        drive(7, 0, 9, 5, 0, 1, 0, 5, 32'hABCD, 1);
        chk("t4_same_cycle", issue_ready, 0);
        step();
        drive(8, 9, 9, 0, 0, 0, 0, 32'hABCD, 32'hABCD, 1);
        step();
        dispatch_en = 0;
        cdb_valid = 0;
        issue_take(7);
        issue_take(8);
        // full queue, dropped dispatch, simultaneous dispatch+issue
        for (int k = 0; k < 4; k++) begin
            drive(6'(10 + k), 0, 0, k, k + 100, 1, 1, k, k + 100, 1);
            step();
        end
        dispatch_en = 0;
        chk("t5_full_count", count, 4);
        chk("t5_full_dready", dispatch_ready, 0);
        drive(14, 0, 0, 1, 1, 1, 1, 1, 1, 0);
        step();
        dispatch_en = 0;
        chk("t5_drop_count", count, 4);
        issue_take(10);
        chk("t5_count3", count, 3);
        drive(15, 0, 0, 32'h15, 32'h51, 1, 1, 32'h15, 32'h51, 1);
        issue_take(11);
        dispatch_en = 0;
        chk("t5_simul_count", count, 3);
        issue_take(12);
        issue_take(13);
        issue_take(15);
        chk("t5_empty_count", count, 0);
        chk("t5_empty_iready", issue_ready, 0);
        // flush with pending dispatch and issue
        drive(20, 30, 0, 0, 1, 0, 1, 0, 1, 1);
        step();
        drive(21, 30, 0, 0, 1, 0, 1, 0, 1, 1);
        step();
        drive(22, 0, 0, 3, 4, 1, 1, 3, 4, 1);
        step();
        chk("t6_count3", count, 3);
        drive(23, 0, 0, 1, 1, 1, 1, 1, 1, 0);
        flush = 1; issue_done = 1;
        chk("t6_preflush_ready", issue_ready, 1);
        chk("t6_preflush_rdtag", issue_rdtag, 22);
        step();
        flush = 0; issue_done = 0; dispatch_en = 0;
        sb.delete();
        chk("t6_flush_count", count, 0);
        chk("t6_flush_iready", issue_ready, 0);
        // async reset during a wakeup broadcast
        drive(24, 0, 0, 1, 1, 1, 1, 1, 1, 1);
        step();
        drive(25, 40, 0, 0, 1, 0, 1, 32'h99, 1, 1);
        step();
        dispatch_en = 0;
        chk("t6_count2", count, 2);
        cdb_valid = 1; cdb_tag = 40; cdb_data = 32'h99;
        reset = 0;
        #1;
        chk("t6_areset_count", count, 0);
        chk("t6_areset_dready", dispatch_ready, 1);
        chk("t6_areset_iready", issue_ready, 0);
        chk("t6_areset_rdtag", issue_rdtag, 0);
        chk("t6_areset_rsdata", issue_rsdata, 0);
        @(posedge clk);
        #1;
        cdb_valid = 0;
        reset = 1;
        sb.delete();
        step();
        chk("t6_post_count", count, 0);
        chk("t6_post_iready", issue_ready, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
